// File: rtl/noc_switch.sv
// noc_switch: 5-port crossbar for a 2D-mesh NoC router.
//
// Each input presents a 3-bit destination request (0=L, 1=N, 2=E, 3=S,
// 4=W, 5..7 idle). Every output has its own round-robin arbiter. A granted
// input keeps its output for as long as it keeps requesting it. Grants and
// output data are registered, so the switch has a 1-cycle latency and no
// combinational path from any input to any output.
//
// Ports:
//   clk                         clock, rising edge
//   rst                         synchronous reset, active-low
//   In_L/N/E/W/S     [DW-1:0]   input flits
//   request_L/N/E/S/W [2:0]     destination request per input
//   Out_L/N/E/W/S    [DW-1:0]   output flits (0 while the output is unowned)
//   grant_L/N/E/S/W             input currently owns its requested output
module noc_switch #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] In_L,
  input  logic [DW-1:0] In_N,
  input  logic [DW-1:0] In_E,
  input  logic [DW-1:0] In_W,
  input  logic [DW-1:0] In_S,
  input  logic [2:0]    request_L,
  input  logic [2:0]    request_N,
  input  logic [2:0]    request_E,
  input  logic [2:0]    request_S,
  input  logic [2:0]    request_W,
  output logic [DW-1:0] Out_L,
  output logic [DW-1:0] Out_N,
  output logic [DW-1:0] Out_E,
  output logic [DW-1:0] Out_W,
  output logic [DW-1:0] Out_S,
  output logic          grant_L,
  output logic          grant_N,
  output logic          grant_E,
  output logic          grant_S,
  output logic          grant_W
);

  // Port index order used everywhere: L=0, N=1, E=2, S=3, W=4.
  logic [4:0][DW-1:0] in_a;
  logic [4:0][2:0]    req_a;

  assign in_a  = {In_W, In_S, In_E, In_N, In_L};
  assign req_a = {request_W, request_S, request_E, request_N, request_L};

  // Arbitration state per output.
  logic [4:0]         own_q;
  logic [4:0][2:0]    owner_q;
  logic [4:0][2:0]    ptr_q;

  logic [4:0]         own_n;
  logic [4:0][2:0]    owner_n;
  logic [4:0][2:0]    ptr_n;
  logic [4:0]         grant_n;
  logic [4:0][DW-1:0] out_n;

  // Registered outputs.
  logic [4:0]         grant_p1;
  logic [4:0][DW-1:0] out_p1;

  always_comb begin
    logic       found;
    logic [3:0] sum;
    logic [2:0] idx;

    own_n   = own_q;
    owner_n = owner_q;
    ptr_n   = ptr_q;
    grant_n = '0;
    out_n   = '0;
    found   = 1'b0;
    sum     = '0;
    idx     = '0;

    for (int y = 0; y < 5; y++) begin
      // A lock survives only while the owner still asks for this output;
      // otherwise the output is re-arbitrated in this very cycle.
      if (!(own_q[y] && (req_a[owner_q[y]] == 3'(y)))) begin
        own_n[y]   = 1'b0;
        owner_n[y] = '0;
        found      = 1'b0;
        for (int k = 0; k < 5; k++) begin
          sum = {1'b0, ptr_q[y]} + 4'(k);
          idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
          if (!found && (req_a[idx] == 3'(y))) begin
            found      = 1'b1;
            own_n[y]   = 1'b1;
            owner_n[y] = idx;
            ptr_n[y]   = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
          end
        end
      end

      if (own_n[y]) begin
        grant_n[owner_n[y]] = 1'b1;
        out_n[y]            = in_a[owner_n[y]];
      end
    end
  end

  // ---- stage p1: register arbitration state, grants and switched data ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      own_q    <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      grant_p1 <= '0;
      out_p1   <= '0;
    end else begin
      own_q    <= own_n;
      owner_q  <= owner_n;
      ptr_q    <= ptr_n;
      grant_p1 <= grant_n;
      out_p1   <= out_n;
    end
  end

  assign Out_L   = out_p1[0];
  assign Out_N   = out_p1[1];
  assign Out_E   = out_p1[2];
  assign Out_S   = out_p1[3];
  assign Out_W   = out_p1[4];
  assign grant_L = grant_p1[0];
  assign grant_N = grant_p1[1];
  assign grant_E = grant_p1[2];
  assign grant_S = grant_p1[3];
  assign grant_W = grant_p1[4];

endmodule

// File: tb/tb_noc_switch.sv
// Directed bench for noc_switch: idle, single stream, locked contention,
// parallel outputs, round-robin fairness, mid-stream reset and U-turn.
module tb_noc_switch;

  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] In_L, In_N, In_E, In_W, In_S;
  logic [2:0]    request_L, request_N, request_E, request_S, request_W;
  logic [DW-1:0] Out_L, Out_N, Out_E, Out_W, Out_S;
  logic          grant_L, grant_N, grant_E, grant_S, grant_W;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  noc_switch #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .In_L(In_L), .In_N(In_N), .In_E(In_E), .In_W(In_W), .In_S(In_S),
    .request_L(request_L), .request_N(request_N), .request_E(request_E),
    .request_S(request_S), .request_W(request_W),
    .Out_L(Out_L), .Out_N(Out_N), .Out_E(Out_E), .Out_W(Out_W), .Out_S(Out_S),
    .grant_L(grant_L), .grant_N(grant_N), .grant_E(grant_E),
    .grant_S(grant_S), .grant_W(grant_W)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grant vector packed as {L,N,E,S,W}.
  function automatic logic [31:0] gv();
    return {27'd0, grant_L, grant_N, grant_E, grant_S, grant_W};
  endfunction

  function automatic logic [31:0] ov();
    return {Out_L, Out_N, Out_E, Out_S} | {24'd0, Out_W};
  endfunction

  initial begin
    rst = 1'b0;
    {In_L, In_N, In_E, In_W, In_S} = '0;
    {request_L, request_N, request_E, request_S, request_W} = {5{3'd7}};

    // Reset state
    tick(); tick();
    chk("reset_grants", gv(), 0);
    chk("reset_outs", ov(), 0);

    // Idle after reset
    rst = 1'b1;
    In_L = 8'd11; In_N = 8'd22;
    tick(); tick(); tick();
    chk("idle_grants", gv(), 0);
    chk("idle_outs", ov(), 0);

    // Single stream W -> L
    request_W = 3'd0; In_W = 8'd4; In_L = 8'd0; In_N = 8'd0;
    tick();
    chk("single_grant_W", gv(), 32'b00001);
    chk("single_out_L", Out_L, 4);
    In_W = 8'd5; tick(); chk("stream_out_L_5", Out_L, 5);
    In_W = 8'd6; tick(); chk("stream_out_L_6", Out_L, 6);
    In_W = 8'd7; tick(); chk("stream_out_L_7", Out_L, 7);

    // Contention while locked: E asks for L, W keeps it
    request_E = 3'd0; In_E = 8'd3; In_W = 8'd8;
    tick();
    chk("lock_grants", gv(), 32'b00001);
    chk("lock_out_L_8", Out_L, 8);
    In_W = 8'd9; tick();
    chk("lock_out_L_9", Out_L, 9);

    // Parallel: S -> E alongside W -> L
    request_S = 3'd2; In_S = 8'd5; In_W = 8'd10;
    tick();
    chk("par_grants", gv(), 32'b00011);
    chk("par_out_E", Out_E, 5);
    chk("par_out_L", Out_L, 10);

    // Release W: waiting E takes L in the same edge
    request_W = 3'd7;
    tick();
    chk("release_grants", gv(), 32'b00110);
    chk("release_out_L", Out_L, 3);
    chk("release_out_E", Out_E, 5);

    // Everyone idle
    request_E = 3'd7; request_S = 3'd7;
    tick();
    chk("clear_grants", gv(), 0);
    chk("clear_outs", ov(), 0);

    // Round-robin on output S, pointer starts at L
    In_L = 8'd1; In_N = 8'd2; In_E = 8'd3;
    request_L = 3'd3; request_N = 3'd3; request_E = 3'd3;
    tick();
    chk("rr1_grants", gv(), 32'b10000);
    chk("rr1_out_S", Out_S, 1);
    request_L = 3'd7;
    tick();
    chk("rr2_grants", gv(), 32'b01000);
    chk("rr2_out_S", Out_S, 2);
    request_L = 3'd3; request_N = 3'd7;
    tick();
    chk("rr3_grants", gv(), 32'b00100);
    chk("rr3_out_S", Out_S, 3);
    request_N = 3'd3; request_E = 3'd7;
    tick();
    chk("rr4_grants", gv(), 32'b10000);
    chk("rr4_out_S", Out_S, 1);

    // Reset mid-stream
    rst = 1'b0;
    tick();
    chk("midrst_grants", gv(), 0);
    chk("midrst_outs", ov(), 0);
    rst = 1'b1;
    tick();
    chk("postrst_grants", gv(), 32'b10000);
    chk("postrst_out_S", Out_S, 1);

    // U-turn L -> L; N takes the released S
    request_L = 3'd0;
    tick();
    chk("uturn_grants", gv(), 32'b11000);
    chk("uturn_out_L", Out_L, 1);
    chk("uturn_out_S", Out_S, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
